// File: rtl/mult4b_seq.sv
// Sequential 4x4 unsigned shift-add multiplier with a start/busy/done handshake.
// Each RUN cycle performs one conditional 4-bit add followed by a right shift.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// RUN   | four add/shift iterations, busy high
// DONE  | one-cycle done pulse, product already on P
module mult4b_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t     state;
    logic [3:0] acc;
    logic [3:0] q;
    logic [3:0] m;
    logic [1:0] cnt;

    logic [4:0] sum;
    logic [3:0] acc_next;
    logic [3:0] q_next;

    // {carry, sum, q} shifted right by one: carry lands in acc[3], sum[0] in q[3]
    always_comb begin
        sum      = q[0] ? ({1'b0, acc} + {1'b0, m}) : {1'b0, acc};
        acc_next = sum[4:1];
        q_next   = {sum[0], q[3:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= 4'h0;
            q     <= 4'h0;
            m     <= 4'h0;
            cnt   <= 2'd0;
            P     <= 8'h00;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        m     <= A;
                        q     <= B;
                        acc   <= 4'h0;
                        cnt   <= 2'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    q   <= q_next;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        P     <= {acc_next, q_next};
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult4b_seq.sv
// Self-checking bench for mult4b_seq: vector table, hand-written corner sequences,
// random operands and an exhaustive sweep, all against plain a*b arithmetic.
module tb_mult4b_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] A = 4'h0;
    logic [3:0] B = 4'h0;
    logic [7:0] P;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    mult4b_seq dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .P    (P),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b);
        int prod;
        prod = int'(a) * int'(b);
        return 8'(prod);
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at the negedge after DONE,
    // when the DUT is again in IDLE, so calls can be issued back to back.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
        start = 1'b1;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        A     = 4'($urandom);
        B     = 4'($urandom);
        for (int k = 0; k < 4; k++) begin
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("product", 32'(P), 32'(exp));
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("product_held", 32'(P), 32'(exp));
    endtask

    initial begin
        tbl[0] = '{4'hF, 4'hF, 8'hE1};
        tbl[1] = '{4'd7, 4'd3, 8'd21};
        tbl[2] = '{4'd0, 4'd9, 8'h00};
        tbl[3] = '{4'd9, 4'd0, 8'h00};
        tbl[4] = '{4'd1, 4'd1, 8'd1};
        tbl[5] = '{4'd15, 4'd1, 8'd15};
        tbl[6] = '{4'd8, 4'd8, 8'd64};
        tbl[7] = '{4'd1, 4'd15, 8'd15};

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_P", 32'(P), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) run_op(tbl[i].a, tbl[i].b, tbl[i].p);

        // start re-asserted mid-operation with new operands is ignored
        start = 1'b1; A = 4'd5; B = 4'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; A = 4'd2; B = 4'd2;
        @(negedge clk);
        chk("ign_busy", 32'(busy), 32'd1);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_product", 32'(P), 32'd30);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ign_no_second_busy", 32'(busy), 32'd0);
            chk("ign_no_second_done", 32'(done), 32'd0);
        end

        // asynchronous reset in RUN cycle 3 discards the operation at once
        start = 1'b1; A = 4'd12; B = 4'd11;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_P", 32'(P), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("abort_quiet_done", 32'(done), 32'd0);
        end
        run_op(4'd3, 4'd4, 8'd12);

        // start held high: one idle cycle between done and the next busy
        start = 1'b1; A = 4'd10; B = 4'd13;
        for (int op = 0; op < 3; op++) begin
            int budget;
            budget = 0;
            @(negedge clk);
            while (!done && budget < 10) begin
                @(negedge clk);
                budget++;
            end
            chk("held_done_seen", 32'(done), 32'd1);
            chk("held_product", 32'(P), 32'd130);
            chk("held_no_overlap", 32'(busy), 32'd0);
            @(negedge clk);
            chk("held_idle_busy", 32'(busy), 32'd0);
            chk("held_idle_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        chk("held_restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        repeat (6) @(negedge clk);

        // random operands against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            ra = 4'($urandom);
            rb = 4'($urandom);
            run_op(ra, rb, model(ra, rb));
        end

        // exhaustive sweep
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_op(4'(a), 4'(b), model(4'(a), 4'(b)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult4b_seq.md
Name: mult4b_seq

Overview:
- Sequential 4x4 unsigned shift-add multiplier sitting downstream of the ALU's 4-bit ripple adder.
- Consumes one 4-bit add per cycle (accumulator + multiplicand) and produces an 8-bit product after 4 iterations.
- Provides the MUL operation for the ALU with a start/busy/done handshake.

Parameters:
- None. Width is fixed at 4 bits to match the ALU datapath.

Ports:
- clk    input   1  system clock, rising edge
- rst    input   1  asynchronous reset, active-high
- start  input   1  request; sampled only in IDLE
- A      input   4  multiplicand, unsigned, captured on accepted start
- B      input   4  multiplier, unsigned, captured on accepted start
- P      output  8  product, registered, held until next completion
- busy   output  1  high while an operation is in progress (RUN state)
- done   output  1  one-cycle pulse when P is updated

Behaviour:
- Reset (async, rst=1): state=IDLE; P=8'h00, busy=0, done=0; internal acc, q, m and cnt cleared. Applies immediately, including mid-operation; the in-flight result is discarded.
- State IDLE:
  - busy=0, done=0.
  - start=1 at a clock edge: m<=A, q<=B, acc<=0, cnt<=0, go to RUN.
  - start=0: stay in IDLE.
- State RUN (busy=1), one iteration per cycle:
  - Add: {c,s} = q[0] ? acc+m : {1'b0,acc}. 4-bit add with 1-bit carry-out, carry-in tied 0.
  - Shift: the 9-bit value {c,s,q} shifts right by 1, so acc<={c,s[3:1]} and q<={s[0],q[3:1]}.
  - cnt increments each cycle. On the edge where cnt==3: P<={acc_next,q_next}, go to DONE.
- State DONE:
  - done=1, busy=0, for exactly one cycle, then IDLE.
  - start in DONE is ignored. The next start is accepted in IDLE, one cycle later.
- Latency: start accepted at edge N, done=1 during cycle N+5 (4 RUN cycles + DONE). P changes only at the edge entering DONE.
- Start while busy or done is ignored. A and B may change freely after acceptance without affecting the result.
- Arithmetic: unsigned only. Product max 15*15=225 (8'hE1); no overflow is possible in 8 bits.
- No illegal-state lockup: the 2-bit state encoding's unused value returns to IDLE on the next edge.

Test Plan:
1. rst pulse, then A=4'hF, B=4'hF, start for 1 cycle -> busy=1 for 4 cycles, done pulse at cycle 5, P=8'hE1 and held.
2. A=7, B=3 -> P=8'd21. Then A=0, B=9 -> P=8'h00. Then A=9, B=0 -> P=8'h00. Each completes in 5 cycles.
3. Start A=5, B=6. In RUN cycle 2, assert start with A=2, B=2 and change A/B -> ignored. P=8'd30, a single done pulse, no second operation.
4. Start A=12, B=11. Assert rst asynchronously in RUN cycle 3 -> P=0, busy=0, done=0 immediately. After release, start A=3, B=4 -> P=8'd12.
5. start held high continuously with A=10, B=13 -> repeated operations with one idle cycle between done and the next busy. Each done carries P=8'd130.
6. Exhaustive: all 256 A/B pairs back-to-back -> P==A*B at every done, done pulse width 1, busy never overlaps done.
